// File: rtl/approx_prod_accumulator.sv
// approx_prod_accumulator
// Sums unsigned 16-bit products from an 8x8 approximate multiplier into
// groups. A group ends on in_last or after MAX_LEN beats. The sum saturates
// at 2^ACC_W-1 and sets a sticky flag. Each group result is held until the
// downstream takes it. A new beat can be accepted in the same cycle that a
// held result is taken, so back-to-back groups lose no cycles.
module approx_prod_accumulator #(
    parameter int ACC_W   = 18,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

    logic [ACC_W-1:0] out_sum_nxt;
    logic [CNT_W-1:0] out_count_nxt;
    logic             out_sat_nxt;

    logic             beat_acc;
    logic             out_take;
    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_sat;
    logic [ACC_W-1:0] sum_sat;
    logic             sum_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             grp_close;

    // Unsigned add of a zero-extended product, clamped to the accumulator
    // maximum. Bit ACC_W of the return value flags that clamping happened.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [15:0]      p
    );
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + {{(ACC_W - 15){1'b0}}, p};
        if (wide[ACC_W]) begin
            sat_add = {1'b1, ACC_MAX};
        end else begin
            sat_add = wide;
        end
    endfunction

    // In HOLD the only way to take a beat is to take the result as well.
    // So in_ready follows out_ready there and is 1 in every other state.
    always_comb begin
        in_ready = 1'b1;
        if (state == HOLD) begin
            in_ready = out_ready;
        end
    end

    // out_valid comes straight from the state register. It is therefore a
    // registered output and can only fall through an out-handshake.
    always_comb begin
        out_valid = (state == HOLD);
    end

    // Beat datapath. In HOLD a beat always starts a fresh group. acc, cnt and
    // sat are already cleared there, but the explicit zero base keeps that
    // guarantee local to this block.
    always_comb begin
        beat_acc  = in_valid && in_ready;
        out_take  = out_valid && out_ready;
        base_acc  = (state == HOLD) ? '0 : acc;
        base_cnt  = (state == HOLD) ? '0 : cnt;
        base_sat  = (state == HOLD) ? 1'b0 : sat;
        {sum_ovf, sum_sat} = sat_add(base_acc, in_prod);
        cnt_inc   = base_cnt + CNT_W'(1);
        grp_close = in_last || (cnt_inc == LEN_MAX);
    end

    // Next-state and next-register logic. A closing beat hands its result to
    // the output registers and clears the running group in the same edge.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        sat_nxt       = sat;
        out_sum_nxt   = out_sum;
        out_count_nxt = out_count;
        out_sat_nxt   = out_sat;

        if (beat_acc) begin
            if (grp_close) begin
                state_nxt     = HOLD;
                out_sum_nxt   = sum_sat;
                out_count_nxt = cnt_inc;
                out_sat_nxt   = base_sat || sum_ovf;
                acc_nxt       = '0;
                cnt_nxt       = '0;
                sat_nxt       = 1'b0;
            end else begin
                state_nxt = ACCUM;
                acc_nxt   = sum_sat;
                cnt_nxt   = cnt_inc;
                sat_nxt   = base_sat || sum_ovf;
            end
        end else if (out_take) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
        end
    end

    // State and group registers. Reset drops any partial group or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    // Result registers. They stay frozen while a result is held and refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_sum   <= out_sum_nxt;
            out_count <= out_count_nxt;
            out_sat   <= out_sat_nxt;
        end
    end

endmodule

// File: doc/approx_prod_accumulator.md
APPROX_PROD_ACCUMULATOR -- requirements
Module: approx_prod_accumulator

Interface
REQ-001 Parameter: ACC_W, default 18, accumulator and result width in bits (minimum 16).
REQ-002 Parameter: MAX_LEN, default 16, maximum products per accumulation group (minimum 1).
REQ-003 Parameter: CNT_W, default $clog2(MAX_LEN+1), width of the beat-count output.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_valid  input  1  upstream product beat valid.
REQ-007 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-008 Port: in_prod  input  16  unsigned 16-bit product from the upstream 8x8 approximate multiplier.
REQ-009 Port: in_last  input  1  beat closes the current group.
REQ-010 Port: out_valid  output  1  group result valid.
REQ-011 Port: out_ready  input  1  downstream accepts the result.
REQ-012 Port: out_sum  output  ACC_W  saturated group sum.
REQ-013 Port: out_count  output  CNT_W  number of beats in the group (1..MAX_LEN).
REQ-014 Port: out_sat  output  1  sum saturated at some point in the group.

Function
REQ-015 In-handshake: a beat is accepted when in_valid and in_ready are both high at a rising edge. Out-handshake: a result is taken when out_valid and out_ready are both high.
REQ-016 FSM states: IDLE (acc=0, cnt=0), ACCUM (partial group held), HOLD (result presented).
REQ-017 in_ready: 1 in IDLE and ACCUM; equals out_ready in HOLD (combinational bypass).
REQ-018 Accumulation: next acc = acc + zero-extended in_prod. If the true sum exceeds 2^ACC_W-1, acc is set to 2^ACC_W-1 and the sticky sat flag is set. Saturation holds for the rest of the group.
REQ-019 cnt increments by 1 per accepted beat.
REQ-020 Group close: an accepted beat closes the group when in_last=1 or cnt+1 == MAX_LEN. Both conditions together close it once.
REQ-021 On group close, the updated acc/cnt/sat are registered into out_sum/out_count/out_sat, out_valid=1 from the next cycle (latency 1 cycle after the last accepted beat), and the state goes to HOLD.
REQ-022 Accepted non-closing beat: IDLE->ACCUM, or stay in ACCUM.
REQ-023 HOLD: out_sum, out_count and out_sat stay stable while out_valid=1 and out_ready=0. out_valid does not drop without an out-handshake.
REQ-024 HOLD exit on out-handshake with no beat accepted: state goes to IDLE, acc/cnt/sat clear, out_valid=0 next cycle.
REQ-025 HOLD exit on out-handshake with a beat accepted in the same cycle:
- the beat starts a new group from acc=0, cnt=0, sat=0;
- the state goes to ACCUM, or back to HOLD if that beat closes its group (MAX_LEN=1 or in_last=1);
- no beat is lost and no cycle is inserted.
REQ-026 A beat is never accepted when in_ready=0. in_prod/in_last are ignored when in_valid=0.
REQ-027 out_sum/out_count/out_sat are don't-care when out_valid=0 but are registered, not combinational.

Reset
REQ-028 rst_n low asynchronously forces:
- state=IDLE, acc=0, cnt=0, sat=0;
- out_valid=0, out_sum=0, out_count=0, out_sat=0.
REQ-029 in_ready is 1 while in reset and in the first cycle after release.
REQ-030 Reset asserted mid-group or in HOLD discards the partial group or pending result. No output is produced for it after release.
REQ-031 Deassertion is synchronous to clk at the integration level. The block needs no extra cycles after release before accepting beats.

Verification
REQ-032 Basic group: beats 100, 200, 300 (last on 300), out_ready=1 -> one cycle after 300 is accepted, out_valid=1, out_sum=600, out_count=3, out_sat=0.
REQ-033 Saturation: five beats of 65025, last on the fifth, ACC_W=18 -> out_sum=262143, out_count=5, out_sat=1. The next group of 7 (last) -> out_sum=7, out_sat=0.
REQ-034 Max length: 16 beats of 1 with in_last=0 throughout -> group closes on the 16th beat, out_sum=16, out_count=16. The 17th beat starts a new group.
REQ-035 Backpressure and bypass:
- first phase: group 5, 6 (last) with out_ready=0 for 4 cycles -> out_sum=11 stable, in_ready=0;
- second phase: raise out_ready with in_valid=1, in_prod=9 -> result taken and 9 accepted in the same cycle, next group sums from 9.
REQ-036 Reset mid-operation: accept 1000, 2000 (no last), pulse rst_n low, release, send 3 (last) -> out_sum=3, out_count=1. No output carries 1000 or 2000.
